// File: rtl/track_collision_seq_if.sv
// Request/result and descriptor-table signals of the sequential track collision scanner.
// slave is the scanner side, master is the car-physics / table side.
interface track_collision_seq_if #(
    parameter int TRACK_COUNT = 12,
    parameter int COOR_W      = 12,
    parameter int VEL_W       = 16,
    parameter int RAD_W       = 6
);
    localparam int IDX_W  = (TRACK_COUNT > 1) ? $clog2(TRACK_COUNT) : 1;
    localparam int DESC_W = 4 + 8*COOR_W;

    logic                   i_start;
    logic [COOR_W-1:0]      i_x;
    logic [COOR_W-1:0]      i_y;
    logic [VEL_W-1:0]       i_v_x;
    logic [VEL_W-1:0]       i_v_y;
    logic [RAD_W-1:0]       i_radius;
    logic [DESC_W-1:0]      i_trk_desc;
    logic                   o_busy;
    logic                   o_done;
    logic [IDX_W-1:0]       o_trk_addr;
    logic [VEL_W-1:0]       o_v_x;
    logic [VEL_W-1:0]       o_v_y;
    logic                   o_collision;
    logic [TRACK_COUNT-1:0] o_collision_mask;
    logic [TRACK_COUNT-1:0] o_in_region_mask;
    logic [IDX_W-1:0]       o_hit_idx;
    logic                   o_on_track;
    logic [1:0]             o_surface;

    modport slave (
        input  i_start, i_x, i_y, i_v_x, i_v_y, i_radius, i_trk_desc,
        output o_busy, o_done, o_trk_addr, o_v_x, o_v_y, o_collision,
               o_collision_mask, o_in_region_mask, o_hit_idx, o_on_track, o_surface
    );
    modport master (
        output i_start, i_x, i_y, i_v_x, i_v_y, i_radius, i_trk_desc,
        input  o_busy, o_done, o_trk_addr, o_v_x, o_v_y, o_collision,
               o_collision_mask, o_in_region_mask, o_hit_idx, o_on_track, o_surface
    );
endinterface

// File: rtl/track_collision_seq.sv
// Time-multiplexed track collision scanner: one descriptor evaluated per cycle from a
// synchronous table, first colliding track selects the velocity correction.
module track_collision_seq #(
    parameter int TRACK_COUNT = 12,
    parameter int COOR_W      = 12,
    parameter int VEL_W       = 16,
    parameter int RAD_W       = 6
) (
    input logic                  i_clk,
    input logic                  i_rst,
    track_collision_seq_if.slave bus
);
    localparam int IDX_W  = (TRACK_COUNT > 1) ? $clog2(TRACK_COUNT) : 1;
    localparam int DESC_W = 4 + 8*COOR_W;
    localparam int AW     = 2*COOR_W + 2;
    // dot product needs coordinate-times-velocity headroom beyond AW
    localparam int DW     = 2*COOR_W + VEL_W + 4;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(TRACK_COUNT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                 state_q;
    logic [COOR_W-1:0]      x_q, y_q;
    logic [VEL_W-1:0]       vx_q, vy_q, ovx_q, ovy_q;
    logic [RAD_W-1:0]       rad_q;
    logic [IDX_W-1:0]       addr_q, eidx_q, ohidx_q;
    logic                   evl_q;
    logic [TRACK_COUNT-1:0] cmask_q, cmask_d, rmask_q, rmask_d;
    logic                   hit_q, hit_d, ont_q, ont_d;
    logic                   fixx_q, fixx_d, fixy_q, fixy_d;
    logic [IDX_W-1:0]       hidx_q, hidx_d;
    logic [1:0]             surf_q, surf_d, osurf_q;

    function automatic logic signed [AW-1:0] sx(input logic [COOR_W-1:0] v);
        return {{(AW-COOR_W){v[COOR_W-1]}}, v};
    endfunction

    logic [DESC_W-1:0]     d;
    logic [1:0]            ty, mat;
    logic signed [AW-1:0]  xl, xr, yt, yb, cx, cy, ri, ro, xs, ys, rs;
    logic signed [AW-1:0]  dx, dy, d2, adx, ady, rout, rin;
    logic signed [DW-1:0]  dxw, dyw, vxw, vyw, dot;
    logic                  inbox, vxp, vxn, vyp, vyn, reg_hit, col_hit, fx, fy;

    assign d   = bus.i_trk_desc;
    assign ty  = d[DESC_W-1 -: 2];
    assign mat = d[DESC_W-3 -: 2];

    always_comb begin
        xl  = sx(d[8*COOR_W-1 -: COOR_W]);
        xr  = sx(d[7*COOR_W-1 -: COOR_W]);
        yt  = sx(d[6*COOR_W-1 -: COOR_W]);
        yb  = sx(d[5*COOR_W-1 -: COOR_W]);
        cx  = sx(d[4*COOR_W-1 -: COOR_W]);
        cy  = sx(d[3*COOR_W-1 -: COOR_W]);
        ri  = sx(d[2*COOR_W-1 -: COOR_W]);
        ro  = sx(d[COOR_W-1:0]);
        xs  = sx(x_q);
        ys  = sx(y_q);
        rs  = {{(AW-RAD_W){1'b0}}, rad_q};
        vxn = vx_q[VEL_W-1];
        vxp = !vx_q[VEL_W-1] && (|vx_q);
        vyn = vy_q[VEL_W-1];
        vyp = !vy_q[VEL_W-1] && (|vy_q);
        inbox = (xl <= xs) && (xs <= xr) && (yb <= ys) && (ys <= yt);
        dx   = xs - cx;
        dy   = ys - cy;
        d2   = dx*dx + dy*dy;
        adx  = dx[AW-1] ? -dx : dx;
        ady  = dy[AW-1] ? -dy : dy;
        rout = ro - rs;
        rin  = ri + rs;
        dxw  = {{(DW-AW){dx[AW-1]}}, dx};
        dyw  = {{(DW-AW){dy[AW-1]}}, dy};
        vxw  = {{(DW-VEL_W){vx_q[VEL_W-1]}}, vx_q};
        vyw  = {{(DW-VEL_W){vy_q[VEL_W-1]}}, vy_q};
        dot  = dxw*vxw + dyw*vyw;
        reg_hit = 1'b0;
        col_hit = 1'b0;
        fx      = 1'b0;
        fy      = 1'b0;
        case (ty)
            2'd0: begin
                reg_hit = inbox;
                col_hit = inbox && ((ys + rs > yt && vyp) || (ys - rs < yb && vyn));
                fy      = 1'b1;
            end
            2'd1: begin
                reg_hit = inbox;
                col_hit = inbox && ((xs + rs > xr && vxp) || (xs - rs < xl && vxn));
                fx      = 1'b1;
            end
            2'd2: begin
                reg_hit = inbox;
                col_hit = inbox && ((d2 > rout*rout && !dot[DW-1] && (|dot)) ||
                                    (d2 < rin*rin && dot[DW-1]));
                // equal magnitudes kill both components
                fx      = (adx >= ady);
                fy      = (ady >= adx);
            end
            default: ;
        endcase

        rmask_d = rmask_q;
        cmask_d = cmask_q;
        hit_d   = hit_q;
        hidx_d  = hidx_q;
        fixx_d  = fixx_q;
        fixy_d  = fixy_q;
        ont_d   = ont_q;
        surf_d  = surf_q;
        if (evl_q) begin
            rmask_d[eidx_q] = reg_hit;
            cmask_d[eidx_q] = col_hit;
            if (col_hit && !hit_q) begin
                hit_d  = 1'b1;
                hidx_d = eidx_q;
                fixx_d = fx;
                fixy_d = fy;
            end
            if (reg_hit && !ont_q) begin
                ont_d  = 1'b1;
                surf_d = mat;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            vx_q    <= '0;
            vy_q    <= '0;
            rad_q   <= '0;
            addr_q  <= '0;
            eidx_q  <= '0;
            evl_q   <= 1'b0;
            cmask_q <= '0;
            rmask_q <= '0;
            hit_q   <= 1'b0;
            hidx_q  <= '0;
            fixx_q  <= 1'b0;
            fixy_q  <= 1'b0;
            ont_q   <= 1'b0;
            surf_q  <= '0;
            ovx_q   <= '0;
            ovy_q   <= '0;
            ohidx_q <= '0;
            osurf_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.i_start) begin
                    state_q <= SCAN;
                    x_q     <= bus.i_x;
                    y_q     <= bus.i_y;
                    vx_q    <= bus.i_v_x;
                    vy_q    <= bus.i_v_y;
                    rad_q   <= bus.i_radius;
                    addr_q  <= '0;
                    eidx_q  <= '0;
                    evl_q   <= 1'b0;
                    cmask_q <= '0;
                    rmask_q <= '0;
                    hit_q   <= 1'b0;
                    hidx_q  <= '0;
                    fixx_q  <= 1'b0;
                    fixy_q  <= 1'b0;
                    ont_q   <= 1'b0;
                    surf_q  <= '0;
                end
                SCAN: begin
                    // table latency: descriptor k arrives one cycle after address k
                    evl_q   <= 1'b1;
                    if (addr_q != LAST) addr_q <= addr_q + 1'b1;
                    cmask_q <= cmask_d;
                    rmask_q <= rmask_d;
                    hit_q   <= hit_d;
                    hidx_q  <= hidx_d;
                    fixx_q  <= fixx_d;
                    fixy_q  <= fixy_d;
                    ont_q   <= ont_d;
                    surf_q  <= surf_d;
                    if (evl_q) begin
                        eidx_q <= eidx_q + 1'b1;
                        if (eidx_q == LAST) begin
                            state_q <= DONE;
                            addr_q  <= '0;
                            ovx_q   <= (hit_d && fixx_d) ? '0 : vx_q;
                            ovy_q   <= (hit_d && fixy_d) ? '0 : vy_q;
                            ohidx_q <= hidx_d;
                            osurf_q <= surf_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_busy           = (state_q == SCAN);
    assign bus.o_done           = (state_q == DONE);
    assign bus.o_trk_addr       = addr_q;
    assign bus.o_v_x            = ovx_q;
    assign bus.o_v_y            = ovy_q;
    assign bus.o_collision_mask = cmask_q;
    assign bus.o_in_region_mask = rmask_q;
    assign bus.o_collision      = |cmask_q;
    assign bus.o_on_track       = |rmask_q;
    assign bus.o_hit_idx        = ohidx_q;
    assign bus.o_surface        = osurf_q;
endmodule

// File: tb/tb_track_collision_seq.sv
// Randomized and directed bench for track_collision_seq against a per-track reference model.
module tb_track_collision_seq;
    localparam int N  = 12;
    localparam int CW = 12;
    localparam int VW = 16;
    localparam int RW = 6;
    localparam int DW = 4 + 8*CW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    track_collision_seq_if #(.TRACK_COUNT(N), .COOR_W(CW), .VEL_W(VW), .RAD_W(RW)) bus();
    track_collision_seq #(.TRACK_COUNT(N), .COOR_W(CW), .VEL_W(VW), .RAD_W(RW)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus.slave));

    track_collision_seq_if #(.TRACK_COUNT(1), .COOR_W(CW), .VEL_W(VW), .RAD_W(RW)) bus1();
    track_collision_seq #(.TRACK_COUNT(1), .COOR_W(CW), .VEL_W(VW), .RAD_W(RW)) dut1 (
        .i_clk(clk), .i_rst(rst), .bus(bus1.slave));

    int n_chk = 0;
    int n_err = 0;
    int t_ty[N], t_mat[N], t_xl[N], t_xr[N], t_yt[N], t_yb[N], t_cx[N], t_cy[N], t_ri[N], t_ro[N];
    int e_rm, e_cm, e_hit, e_vx, e_vy, e_surf, e_ont;
    logic [DW-1:0] one_desc;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack(input int ty, mat, xl, xr, yt, yb, cx, cy, ri, ro);
        return {2'(ty), 2'(mat), CW'(xl), CW'(xr), CW'(yt), CW'(yb), CW'(cx), CW'(cy), CW'(ri), CW'(ro)};
    endfunction

    always @(posedge clk) begin
        if (int'(bus.o_trk_addr) < N)
            bus.i_trk_desc <= pack(t_ty[bus.o_trk_addr], t_mat[bus.o_trk_addr], t_xl[bus.o_trk_addr],
                                   t_xr[bus.o_trk_addr], t_yt[bus.o_trk_addr], t_yb[bus.o_trk_addr],
                                   t_cx[bus.o_trk_addr], t_cy[bus.o_trk_addr], t_ri[bus.o_trk_addr],
                                   t_ro[bus.o_trk_addr]);
        else
            bus.i_trk_desc <= '0;
        bus1.i_trk_desc <= one_desc;
    end

    function automatic longint iabs(input longint a);
        return (a < 0) ? -a : a;
    endfunction

    // Geometry straight from the track rules, scanning the table in index order.
    task automatic model(input int x, y, r, vx, vy);
        longint dx, dy, d2, dot;
        bit inr, col, found;
        found = 0; e_rm = 0; e_cm = 0; e_hit = 0; e_vx = vx; e_vy = vy; e_surf = 0; e_ont = 0;
        for (int k = 0; k < N; k++) begin
            dx  = longint'(x) - t_cx[k];
            dy  = longint'(y) - t_cy[k];
            d2  = dx*dx + dy*dy;
            dot = dx*vx + dy*vy;
            inr = (t_ty[k] != 3) && x >= t_xl[k] && x <= t_xr[k] && y >= t_yb[k] && y <= t_yt[k];
            col = 0;
            if (t_ty[k] == 0) col = inr && ((y + r > t_yt[k] && vy > 0) || (y - r < t_yb[k] && vy < 0));
            if (t_ty[k] == 1) col = inr && ((x + r > t_xr[k] && vx > 0) || (x - r < t_xl[k] && vx < 0));
            if (t_ty[k] == 2) col = inr && ((d2 > longint'(t_ro[k]-r)*(t_ro[k]-r) && dot > 0) ||
                                            (d2 < longint'(t_ri[k]+r)*(t_ri[k]+r) && dot < 0));
            if (inr) e_rm |= (1 << k);
            if (col) e_cm |= (1 << k);
            if (inr && !e_ont) begin e_ont = 1; e_surf = t_mat[k]; end
            if (col && !found) begin
                found = 1;
                e_hit = k;
                if (t_ty[k] == 0) e_vy = 0;
                if (t_ty[k] == 1) e_vx = 0;
                if (t_ty[k] == 2) begin
                    if (iabs(dx) >= iabs(dy)) e_vx = 0;
                    if (iabs(dy) >= iabs(dx)) e_vy = 0;
                end
            end
        end
    endtask

    task automatic set_trk(input int k, ty, mat, xl, xr, yt, yb, cx, cy, ri, ro);
        t_ty[k] = ty; t_mat[k] = mat; t_xl[k] = xl; t_xr[k] = xr; t_yt[k] = yt; t_yb[k] = yb;
        t_cx[k] = cx; t_cy[k] = cy; t_ri[k] = ri; t_ro[k] = ro;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, bus.o_busy, 0);
        chk({tag, "_done"}, bus.o_done, 0);
        chk({tag, "_addr"}, bus.o_trk_addr, 0);
        chk({tag, "_outs"}, {bus.o_v_x, bus.o_v_y, bus.o_collision_mask, bus.o_in_region_mask,
                             bus.o_hit_idx, bus.o_surface, bus.o_collision, bus.o_on_track}, 0);
    endtask

    task automatic scan(input string tag, input int x, y, r, vx, vy, input int restart_at, input int rst_at);
        int c, nb, nd;
        bit seen;
        model(x, y, r, vx, vy);
        @(negedge clk);
        bus.i_x = CW'(x); bus.i_y = CW'(y); bus.i_radius = RW'(r);
        bus.i_v_x = VW'(vx); bus.i_v_y = VW'(vy);
        bus.i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_start = 1'b0;
        c = 1; nb = 0; seen = 0;
        chk({tag, "_mask_clr"}, {bus.o_collision_mask, bus.o_in_region_mask}, 0);
        while (c <= N + 8 && !seen) begin
            if (bus.o_done) seen = 1;
            else begin
                if (bus.o_busy) nb++;
                if (c <= N) chk({tag, "_addr"}, bus.o_trk_addr, c - 1);
                bus.i_start = (c == restart_at);
                rst = (c == rst_at);
                @(posedge clk);
                @(negedge clk);
                bus.i_start = 1'b0;
                rst = 1'b0;
                c++;
                if (rst_at != 0 && c == rst_at + 1) begin
                    chk_idle_zero({tag, "_rst"});
                    nd = 0;
                    for (int i = 0; i < 20; i++) begin
                        @(negedge clk);
                        if (bus.o_done || bus.o_busy) nd++;
                    end
                    chk({tag, "_no_done_after_rst"}, nd, 0);
                    return;
                end
            end
        end
        chk({tag, "_done_cycle"}, c, N + 2);
        chk({tag, "_busy_cycles"}, nb, N + 1);
        chk({tag, "_busy_at_done"}, bus.o_busy, 0);
        chk({tag, "_cmask"}, bus.o_collision_mask, e_cm);
        chk({tag, "_rmask"}, bus.o_in_region_mask, e_rm);
        chk({tag, "_coll"}, bus.o_collision, (e_cm != 0));
        chk({tag, "_ontrk"}, bus.o_on_track, e_ont);
        chk({tag, "_hit"}, bus.o_hit_idx, e_hit);
        chk({tag, "_surf"}, bus.o_surface, e_surf);
        chk({tag, "_vx"}, $signed(bus.o_v_x), e_vx);
        chk({tag, "_vy"}, $signed(bus.o_v_y), e_vy);
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.o_done || bus.o_busy) nd++;
        end
        chk({tag, "_single_done"}, nd, 0);
        chk({tag, "_vx_hold"}, $signed(bus.o_v_x), e_vx);
    endtask

    task automatic rand_tbl(input int x, y);
        for (int k = 0; k < N; k++) begin
            int xl, yb;
            xl = x + 40 - int'($urandom_range(0, 200));
            yb = y + 40 - int'($urandom_range(0, 200));
            set_trk(k, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    xl, xl + int'($urandom_range(0, 300)), yb + int'($urandom_range(0, 300)), yb,
                    x + int'($urandom_range(0, 400)) - 200, y + int'($urandom_range(0, 400)) - 200,
                    0, 0);
            t_ri[k] = int'($urandom_range(0, 200));
            t_ro[k] = t_ri[k] + int'($urandom_range(0, 300));
        end
    endtask

    function automatic int rvel();
        return ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 4000)) - 2000;
    endfunction

    initial begin
        int c1, x, y;
        rst = 1'b1;
        bus.i_start = 0; bus.i_x = 0; bus.i_y = 0; bus.i_v_x = 0; bus.i_v_y = 0; bus.i_radius = 0;
        bus1.i_start = 0; bus1.i_x = 0; bus1.i_y = 0; bus1.i_v_x = 0; bus1.i_v_y = 0; bus1.i_radius = 0;
        one_desc = pack(0, 2, -100, 100, 100, -100, 0, 0, 0, 0);
        for (int k = 0; k < N; k++) set_trk(k, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_idle_zero("reset");
        chk("reset1_busy", bus1.o_busy, 0);

        // T0: horizontal wall, moving up into top edge
        set_trk(0, 0, 0, -550, 530, -250, -365, 0, 0, 0, 0);
        scan("t0", 0, -260, 20, 'h80, 'h100, 0, 0);
        chk("t0_cmask_k", bus.o_collision_mask, 'h001);
        chk("t0_vy_k", bus.o_v_y, 0);
        chk("t0_vx_k", bus.o_v_x, 'h80);

        // T1/T2: circle outer wall, moving away from centre then toward it
        set_trk(1, 2, 0, -770, -550, -150, -370, -550, -150, 100, 215);
        scan("t1", -750, -150, 20, -'h100, 0, 0, 0);
        chk("t1_hit_k", bus.o_hit_idx, 1);
        chk("t1_vx_k", bus.o_v_x, 0);
        scan("t2", -750, -150, 20, 'h100, 0, 0, 0);
        chk("t2_coll_k", bus.o_collision, 0);
        chk("t2_vx_k", bus.o_v_x, 'h100);
        chk("t2_ontrk_k", bus.o_on_track, 1);

        // T3: sand region, zero velocity
        set_trk(5, 0, 1, 900, 1100, 1100, 900, 0, 0, 0, 0);
        scan("t3", 1000, 1000, 10, 0, 0, 0, 0);
        chk("t3_surf_k", bus.o_surface, 1);
        chk("t3_rmask_k", bus.o_in_region_mask, 'h020);

        // T4 second start ignored, T5 reset mid-scan then normal run
        scan("t4", 0, -260, 20, 'h80, 'h100, 5, 0);
        scan("t5", 0, -260, 20, 'h80, 'h100, 0, 6);
        scan("t5b", 0, -260, 20, 'h80, 'h100, 0, 0);

        // overlapping regions: same box twice, lowest index must win
        set_trk(2, 1, 3, -100, 50, 100, -100, 0, 0, 0, 0);
        set_trk(3, 0, 2, -100, 50, 100, -100, 0, 0, 0, 0);
        scan("ovl", 45, 95, 10, 'h40, 'h40, 0, 0);
        chk("ovl_hit_k", bus.o_hit_idx, 2);

        for (int it = 0; it < 40; it++) begin
            x = int'($urandom_range(0, 600)) - 300;
            y = int'($urandom_range(0, 600)) - 300;
            rand_tbl(x, y);
            scan("rnd", x, y, int'($urandom_range(0, 63)), rvel(), rvel(), 0, 0);
        end

        // single-track instance
        @(negedge clk);
        bus1.i_x = 0; bus1.i_y = CW'(95); bus1.i_radius = RW'(10);
        bus1.i_v_x = VW'(7); bus1.i_v_y = VW'(10); bus1.i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.i_start = 1'b0;
        c1 = 1;
        while (!bus1.o_done && c1 < 10) begin
            @(negedge clk);
            c1++;
        end
        chk("n1_done_cycle", c1, 3);
        chk("n1_cmask", bus1.o_collision_mask, 1);
        chk("n1_vy", bus1.o_v_y, 0);
        chk("n1_vx", bus1.o_v_x, 7);
        chk("n1_surf", bus1.o_surface, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
